// File: rtl/pixel_shuffle_writer_if.sv
// pixel_shuffle_writer_if: control, input-beat and framebuffer-write bundle for pixel_shuffle_writer.
// PS_STALL_CNT_EN adds the stall_cycles observation signal.
interface pixel_shuffle_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19
);
  logic start;
  logic in_valid;
  logic in_ready;
  logic [12*DATA_WIDTH-1:0] in_data;
  logic fb_we;
  logic fb_ready;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [3*DATA_WIDTH-1:0] fb_data;
  logic busy;
  logic frame_done;
`ifdef PS_STALL_CNT_EN
  logic [31:0] stall_cycles;
  modport master (output start, in_valid, in_data, fb_ready,
                  input in_ready, fb_we, fb_addr, fb_data, busy, frame_done, stall_cycles);
  modport slave (input start, in_valid, in_data, fb_ready,
                 output in_ready, fb_we, fb_addr, fb_data, busy, frame_done, stall_cycles);
`else
  modport master (output start, in_valid, in_data, fb_ready,
                  input in_ready, fb_we, fb_addr, fb_data, busy, frame_done);
  modport slave (input start, in_valid, in_data, fb_ready,
                 output in_ready, fb_we, fb_addr, fb_data, busy, frame_done);
`endif
endinterface

// File: rtl/pixel_shuffle_writer.sv
// pixel_shuffle_writer: 2x depth-to-space of 12-channel beats into four RGB framebuffer writes.
// Optional macro PS_STALL_CNT_EN adds a saturating fb backpressure cycle counter.
module pixel_shuffle_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 320,
  parameter int IN_HEIGHT  = 240,
  parameter int ADDR_WIDTH = 19
) (
  input logic clk,
  input logic rst_n,
  pixel_shuffle_writer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_IN = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam int XW = $clog2(IN_WIDTH + 1);
  localparam int YW = $clog2(IN_HEIGHT + 1);
  localparam int CW = 12 * DATA_WIDTH;
  localparam int PW = 3 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO      = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] LINE_M1  = ADDR_WIDTH'(2 * IN_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(4 * IN_WIDTH);
  localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);

  logic [1:0] state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0] k_q, k_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d, col_q, col_d, addr_q, addr_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [PW-1:0] data_q, data_d;
  logic in_ready_q, in_ready_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic in_hs, wr_hs, last_x, last_px;

  function automatic logic [PW-1:0] sub_pix(input logic [CW-1:0] v, input logic [1:0] k);
    sub_pix = {v[int'(k)*DATA_WIDTH +: DATA_WIDTH],
               v[(4+int'(k))*DATA_WIDTH +: DATA_WIDTH],
               v[(8+int'(k))*DATA_WIDTH +: DATA_WIDTH]};
  endfunction

  assign in_hs   = in_ready_q && bus.in_valid;
  assign wr_hs   = we_q && bus.fb_ready;
  assign last_x  = x_q == X_LAST;
  assign last_px = last_x && y_q == Y_LAST;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    k_d        = k_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    ch_d       = ch_q;
    data_d     = data_q;
    in_ready_d = in_ready_q;
    we_d       = we_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d    = WAIT_IN;
        busy_d     = 1'b1;
        in_ready_d = 1'b1;
        x_d        = '0;
        y_d        = '0;
        row_d      = '0;
        col_d      = '0;
      end
      WAIT_IN: if (in_hs) begin
        state_d    = WRITE;
        in_ready_d = 1'b0;
        we_d       = 1'b1;
        k_d        = 2'd0;
        ch_d       = bus.in_data;
        addr_d     = row_q + col_q;
        data_d     = sub_pix(bus.in_data, 2'd0);
      end
      WRITE: if (wr_hs) begin
        k_d = k_q + 2'd1;
        if (k_q != 2'd3) begin
          // odd k steps down one output line and back to the left column
          addr_d = addr_q + (k_q[0] ? LINE_M1 : ONE);
          data_d = sub_pix(ch_q, k_q + 2'd1);
        end else begin
          we_d       = 1'b0;
          x_d        = last_x ? '0 : x_q + XW'(1);
          y_d        = last_x ? y_q + YW'(1) : y_q;
          col_d      = last_x ? '0 : col_q + TWO;
          row_d      = last_x ? row_q + ROW_STEP : row_q;
          state_d    = last_px ? DONE : WAIT_IN;
          in_ready_d = !last_px;
          busy_d     = !last_px;
          done_d     = last_px;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      k_q        <= k_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.fb_we      = we_q;
  assign bus.fb_addr    = addr_q;
  assign bus.fb_data    = data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

`ifdef PS_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb begin
    stall_d = (state_q == IDLE && bus.start) ? '0
            : (we_q && !bus.fb_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk) stall_q <= !rst_n ? '0 : stall_d;
  assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pixel_shuffle_writer.sv
// tb_pixel_shuffle_writer: randomized scenarios on a 4x2 frame checked against a pixel-shuffle address/data model.
// Define PS_STALL_CNT_EN to also check stall_cycles.
module tb_pixel_shuffle_writer;
  localparam int DW = 8, W = 4, H = 2, AW = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_err = 0, cyc = 0, beat_idx = 0, stall_obs = 0;
  int exp_addr[$], obs_addr[$], obs_cyc[$], beat_cyc[$], done_cyc[$];
  logic [23:0] exp_data[$], obs_data[$];

  pixel_shuffle_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  pixel_shuffle_writer #(.DATA_WIDTH(DW), .IN_WIDTH(W), .IN_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n) begin
    if (bus.fb_we && bus.fb_ready) begin
      obs_addr.push_back(int'(bus.fb_addr));
      obs_data.push_back(bus.fb_data);
      obs_cyc.push_back(cyc);
    end
    if (bus.fb_we && !bus.fb_ready) stall_obs++;
    if (bus.in_valid && bus.in_ready) beat_cyc.push_back(cyc);
    if (bus.frame_done) done_cyc.push_back(cyc);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [95:0] rand_vec();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Low-res pixel (x,y) covers output pixels (2x+dx, 2y+dy); sub-pixel k takes ch[k], ch[4+k], ch[8+k].
  function automatic void model_beat(input int b, input logic [95:0] v);
    logic [7:0] ch [12];
    int x, y;
    x = b % W;
    y = b / W;
    for (int i = 0; i < 12; i++) ch[i] = v[i*8 +: 8];
    for (int k = 0; k < 4; k++) begin
      exp_addr.push_back((2*y + k/2) * (2*W) + 2*x + k%2);
      exp_data.push_back({ch[k], ch[4+k], ch[8+k]});
    end
  endfunction

  function automatic void clear();
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
    obs_cyc.delete(); beat_cyc.delete(); done_cyc.delete();
    beat_idx = 0;
    stall_obs = 0;
  endfunction

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic stream(input int n, input bit rv, input bit rr, input bit use_fv,
                        input logic [95:0] fv, output bit tmo);
    int sent, t;
    bit hs;
    logic [95:0] v;
    sent = 0;
    t = 0;
    v = use_fv ? fv : rand_vec();
    bus.in_data = v;
    bus.in_valid = (n > 0) && (!rv || $urandom_range(0, 1) == 1);
    bus.fb_ready = !rr || $urandom_range(0, 1) == 1;
    while (!(sent == n && obs_addr.size() == exp_addr.size()) && t < 2000) begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      t++;
      if (hs) begin
        model_beat(beat_idx, v);
        beat_idx++;
        sent++;
        v = rand_vec();
        bus.in_data = v;
        bus.in_valid = 1'b0;
      end
      if (sent < n && !bus.in_valid) bus.in_valid = !rv || $urandom_range(0, 1) == 1;
      bus.fb_ready = !rr || $urandom_range(0, 1) == 1;
    end
    bus.in_valid = 1'b0;
    bus.fb_ready = 1'b1;
    tmo = t >= 2000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.fb_we, bus.busy, bus.frame_done} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/we/busy/done %b want 0000",
               {bus.in_ready, bus.fb_we, bus.busy, bus.frame_done});
    end
    n_cmp++;
    if (bus.fb_addr !== '0 || bus.fb_data !== '0) begin
      n_err++;
      $display("FAIL reset_bus: got addr %0h data %0h want 0 0", bus.fb_addr, bus.fb_data);
    end
`ifdef PS_STALL_CNT_EN
    n_cmp++;
    if (bus.stall_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles);
    end
`endif
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: got busy %b rdy %b want 0 0", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_single_pixel();
    int want_a[4] = '{0, 1, 8, 9};
    logic [23:0] want_d[4] = '{24'h010509, 24'h02060A, 24'h03070B, 24'h04080C};
    bit tmo;
    clear();
    do_start();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_accept: got busy %b rdy %b want 1 1", bus.busy, bus.in_ready);
    end
    stream(1, 1'b0, 1'b0, 1'b1, 96'h0C0B0A09_08070605_04030201, tmo);
    n_cmp++;
    if (tmo || obs_addr.size() != 4 || beat_cyc.size() != 1) begin
      n_err++;
      $display("FAIL single_count: got %0d writes tmo %b want 4 writes", obs_addr.size(), tmo);
    end else
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_addr[i] !== want_a[i] || obs_data[i] !== want_d[i] || obs_cyc[i] !== beat_cyc[0] + 1 + i) begin
          n_err++;
          $display("FAIL single_write[%0d]: got addr %0d data %06h cyc %0d want addr %0d data %06h cyc %0d",
                   i, obs_addr[i], obs_data[i], obs_cyc[i], want_a[i], want_d[i], beat_cyc[0] + 1 + i);
        end
      end
    do_reset();
  endtask

  task automatic test_full_frame();
    int spot_i[8] = '{4, 5, 6, 7, 28, 29, 30, 31};
    int spot_a[8] = '{2, 3, 10, 11, 22, 23, 30, 31};
    bit tmo;
    clear();
    do_start();
    stream(W*H, 1'b0, 1'b0, 1'b0, '0, tmo);
    n_cmp++;
    if (tmo || obs_addr.size() != 4*W*H || beat_cyc.size() != W*H) begin
      n_err++;
      $display("FAIL frame_count: got %0d writes %0d beats tmo %b want 32 8", obs_addr.size(), beat_cyc.size(), tmo);
    end else begin
      for (int i = 0; i < 4*W*H; i++) begin
        n_cmp++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_err++;
          $display("FAIL frame_write[%0d]: got addr %0d data %06h want addr %0d data %06h",
                   i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (obs_addr[spot_i[i]] !== spot_a[i]) begin
          n_err++;
          $display("FAIL frame_spot[%0d]: got addr %0d want %0d", spot_i[i], obs_addr[spot_i[i]], spot_a[i]);
        end
      end
      for (int i = 1; i < W*H; i++) begin
        n_cmp++;
        if (beat_cyc[i] - beat_cyc[i-1] !== 5) begin
          n_err++;
          $display("FAIL beat_spacing[%0d]: got %0d cycles want 5", i, beat_cyc[i] - beat_cyc[i-1]);
        end
      end
    end
    n_cmp++;
    if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_cycle: got done %b busy %b want 1 0", bus.frame_done, bus.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cyc.size() != 1 || obs_cyc.size() == 0 || done_cyc[0] !== obs_cyc[obs_cyc.size()-1] + 1) begin
      n_err++;
      $display("FAIL done_pulse: got %0d pulses want 1 one cycle after last write", done_cyc.size());
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.fb_we !== 1'b0) begin
      n_err++;
      $display("FAIL post_frame_idle: got busy %b rdy %b we %b want 0 0 0", bus.busy, bus.in_ready, bus.fb_we);
    end
`ifdef PS_STALL_CNT_EN
    n_cmp++;
    if (bus.stall_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL frame_stall: got %0d want 0", bus.stall_cycles);
    end
`endif
  endtask

  task automatic test_random();
    bit tmo;
    for (int f = 0; f < 3; f++) begin
      clear();
      do_start();
      stream(W*H, 1'b1, 1'b1, 1'b0, '0, tmo);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (tmo || obs_addr.size() != exp_addr.size() || done_cyc.size() != 1) begin
        n_err++;
        $display("FAIL rand_count[%0d]: got %0d writes %0d dones want %0d 1", f, obs_addr.size(), done_cyc.size(), exp_addr.size());
      end else
        for (int i = 0; i < exp_addr.size(); i++) begin
          n_cmp++;
          if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            n_err++;
            $display("FAIL rand_write[%0d][%0d]: got addr %0d data %06h want addr %0d data %06h",
                     f, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
          end
        end
`ifdef PS_STALL_CNT_EN
      n_cmp++;
      if (bus.stall_cycles !== 32'(stall_obs)) begin
        n_err++;
        $display("FAIL rand_stall[%0d]: got %0d want %0d", f, bus.stall_cycles, stall_obs);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [95:0] v;
    clear();
    do_start();
    v = rand_vec();
    bus.in_data = v;
    bus.in_valid = 1'b1;
    bus.fb_ready = 1'b1;
    model_beat(0, v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.fb_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.fb_we !== 1'b1 || bus.fb_addr !== AW'(1) || bus.fb_data !== exp_data[1] || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got we %b addr %0d data %06h rdy %b want 1 1 %06h 0",
                 s, bus.fb_we, bus.fb_addr, bus.fb_data, bus.in_ready, exp_data[1]);
      end
      @(posedge clk); #1;
    end
    bus.fb_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_addr.size() != 4 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_count: got %0d writes rdy %b want 4 1", obs_addr.size(), bus.in_ready);
    end else
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_err++;
          $display("FAIL stall_write[%0d]: got addr %0d data %06h want addr %0d data %06h",
                   i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
`ifdef PS_STALL_CNT_EN
    n_cmp++;
    if (bus.stall_cycles !== 32'd3) begin
      n_err++;
      $display("FAIL stall_cycles: got %0d want 3", bus.stall_cycles);
    end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit tmo;
    clear();
    do_start();
    stream(3, 1'b0, 1'b0, 1'b0, '0, tmo);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    do_reset();
    n_cmp++;
    if ({bus.in_ready, bus.fb_we, bus.busy, bus.frame_done} !== 4'b0 || bus.fb_addr !== '0 || bus.fb_data !== '0) begin
      n_err++;
      $display("FAIL midreset_outs: got rdy/we/busy/done %b addr %0d data %06h want 0",
               {bus.in_ready, bus.fb_we, bus.busy, bus.frame_done}, bus.fb_addr, bus.fb_data);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cyc.size() != 0 || bus.busy !== 1'b0 || tmo) begin
      n_err++;
      $display("FAIL midreset_quiet: got %0d dones busy %b want 0 0", done_cyc.size(), bus.busy);
    end
    clear();
    do_start();
    stream(1, 1'b0, 1'b0, 1'b0, '0, tmo);
    n_cmp++;
    if (tmo || obs_addr.size() != 4) begin
      n_err++;
      $display("FAIL restart_count: got %0d writes want 4", obs_addr.size());
    end else
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_err++;
          $display("FAIL restart_write[%0d]: got addr %0d data %06h want addr %0d data %06h",
                   i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    do_reset();
  endtask

  task automatic test_start_ignored();
    bit tmo;
    clear();
    do_start();
    stream(2, 1'b0, 1'b0, 1'b0, '0, tmo);
    do_start();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL busy_start: got busy %b rdy %b want 1 1", bus.busy, bus.in_ready);
    end
    stream(W*H - 2, 1'b0, 1'b1, 1'b0, '0, tmo);
    n_cmp++;
    if (bus.frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL done_cycle2: got done %b want 1", bus.frame_done);
    end
    do_start();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.fb_we !== 1'b0 || done_cyc.size() != 1) begin
      n_err++;
      $display("FAIL done_start: got busy %b rdy %b we %b dones %0d want 0 0 0 1",
               bus.busy, bus.in_ready, bus.fb_we, done_cyc.size());
    end
    n_cmp++;
    if (tmo || obs_addr.size() != 4*W*H) begin
      n_err++;
      $display("FAIL ignored_count: got %0d writes want 32", obs_addr.size());
    end else
      for (int i = 0; i < 4*W*H; i++) begin
        n_cmp++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_err++;
          $display("FAIL ignored_write[%0d]: got addr %0d data %06h want addr %0d data %06h",
                   i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    clear();
    do_start();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL new_start: got busy %b rdy %b want 1 1", bus.busy, bus.in_ready);
    end
    stream(W*H, 1'b1, 1'b0, 1'b0, '0, tmo);
    n_cmp++;
    if (tmo || obs_addr.size() != 4*W*H || obs_addr[0] !== 0 || obs_addr[4*W*H-1] !== 4*W*H-1) begin
      n_err++;
      $display("FAIL new_frame: got %0d writes tmo %b want 32 from addr 0 to 31", obs_addr.size(), tmo);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.fb_ready = 1'b1;
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_shuffle_writer.md
Name: pixel_shuffle_writer

Overview:
Consumer side of the super-resolution datapath. Accepts one 12-channel low-res result vector per beat, in raster order, laid out as the upsample stage packs it. Performs 2x depth-to-space (pixel shuffle) into four RGB output pixels. Writes those pixels into the 2x-resolution framebuffer through a valid/ready write port, generating addresses and frame-completion status.

Parameters:
DATA_WIDTH, 8, bits per channel
IN_WIDTH, 320, low-res pixels per line (output line = 2*IN_WIDTH)
IN_HEIGHT, 240, low-res lines per frame (output lines = 2*IN_HEIGHT)
ADDR_WIDTH, 19, framebuffer word address width; must hold 4*IN_WIDTH*IN_HEIGHT-1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  frame start pulse; honoured only in IDLE
in_valid  in  1  in_data valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_data  in  12*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
fb_we  out  1  framebuffer write request
fb_ready  in  1  framebuffer accepts write when fb_we && fb_ready
fb_addr  out  ADDR_WIDTH  output pixel word address
fb_data  out  3*DATA_WIDTH  {R,G,B}, R in MSBs
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after last write of frame

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; in_ready=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_done=0; x/y/sub counters=0. Reset mid-frame aborts silently; no partial-write completion.
- States: IDLE, WAIT_IN, WRITE, DONE.
- IDLE: on start=1 -> WAIT_IN, busy=1, x=y=0. Inputs other than start ignored.
- WAIT_IN: in_ready=1 (registered, only in this state). On handshake, latch in_data, sub=0 -> WRITE. in_ready=0 in all other states.
- WRITE: fb_we=1. fb_addr/fb_data held stable while fb_we && !fb_ready.
  - Sub-pixel k=dy*2+dx, issued in order k=0,1,2,3, i.e. (dx,dy)=(0,0),(1,0),(0,1),(1,1).
  - Data for sub k: R=ch[k], G=ch[4+k], B=ch[8+k].
  - Address: (2y+dy)*(2*IN_WIDTH) + 2x + dx. Generated incrementally from a row-base register; no runtime multiplier.
  - Each accepted write advances k. After k=3 accepted: x++; at x=IN_WIDTH-1, x wraps to 0 and y++.
  - If the pixel was (IN_WIDTH-1, IN_HEIGHT-1) -> DONE, else -> WAIT_IN.
- DONE: frame_done=1 for exactly one cycle, busy=0 -> IDLE.
- Timing: beat accepted at edge N gives fb_we=1 after edge N. With fb_ready held high, the four writes occupy four cycles and in_ready returns one cycle after the 4th write. Peak throughput is 1 input beat per 5 cycles.
- start while busy: ignored. start in the same cycle as frame_done: ignored; a new frame needs start in IDLE.
- fb_we deasserts the cycle after the 4th write is accepted. There are no idle-cycle writes.

Optional Feature:
Macro PS_STALL_CNT_EN.
- Defined: adds output stall_cycles [31:0], incremented each cycle fb_we && !fb_ready. Saturates at 32'hFFFFFFFF, cleared on accepted start and on reset, holds value after frame_done.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Single pixel, IN_WIDTH=4, IN_HEIGHT=2: start, in_data ch[i]=i+1, fb_ready=1 -> writes addr 0,1,8,9 with data 0x010509, 0x02060A, 0x03070B, 0x04080C on consecutive cycles.
- Addressing, IN_WIDTH=4, IN_HEIGHT=2, full frame of 8 beats: beat (x=1,y=0) -> addrs 2,3,10,11; beat (3,1) -> 22,23,30,31. frame_done pulses once, one cycle after addr 31 write; busy falls with it.
- Backpressure: fb_ready=0 for 3 cycles during the k=1 write -> fb_addr=1 and its fb_data held constant, no in_ready. With PS_STALL_CNT_EN, stall_cycles=3.
- in_valid held high continuously -> in_ready pulses exactly once per 5 cycles, and 8 beats are consumed for the 4x2 frame.
- Reset mid-frame after 3 beats: rst_n=0 for one edge -> all outputs 0, IDLE. A new start restarts the frame at addr 0.
- start pulsed while busy and in the frame_done cycle -> no restart, counters unaffected; start in IDLE afterward begins a new frame.
